logic_engine_responder: RTL and testbench

//   Target side of the CPU logic-engine port (logic_req/logic_addr -> logic_ack/logic_data).

---
 rtl/logic_engine_responder_pkg.sv | 23 ++
 rtl/logic_engine_responder_if.sv | 22 ++
 rtl/logic_engine_responder_cache.sv | 43 ++++
 rtl/logic_engine_responder.sv | 143 ++++++++++++++
 tb/tb_logic_engine_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_engine_responder_pkg.sv
// Shared types and constants for the CPU logic-engine responder and its result cache.
package thiele_logic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0]  RSP_PROVED       = 2'b00;
  localparam logic [1:0]  RSP_REFUTED      = 2'b01;
  localparam logic [1:0]  RSP_ERROR        = 2'b10;
  localparam logic [31:0] ERR_CERT_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [31:0] cert_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/logic_engine_responder_if.sv
// CPU logic-engine port plus solver request/response channel, seen from both ends.
interface logic_engine_responder_if;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic        solver_req_valid;
  logic        solver_req_ready;
  logic [31:0] solver_req_addr;
  logic        solver_rsp_valid;
  logic [1:0]  solver_rsp_status;

  modport master (
    output logic_req, logic_addr, solver_req_ready, solver_rsp_valid, solver_rsp_status,
    input  logic_ack, logic_data, solver_req_valid, solver_req_addr
  );

  modport slave (
    input  logic_req, logic_addr, solver_req_ready, solver_rsp_valid, solver_rsp_status,
    output logic_ack, logic_data, solver_req_valid, solver_req_addr
  );
endinterface

// File: rtl/logic_engine_responder_cache.sv
// Direct-mapped result cache: combinational lookup, single-cycle fill, invalidated by reset.
module logic_result_cache #(
  parameter int CACHE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill_en,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data
);
  localparam int IDX_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

  logic [CACHE_DEPTH-1:0] valid_q;
  logic [31:0]            tag_q  [CACHE_DEPTH];
  logic [31:0]            data_q [CACHE_DEPTH];
  logic [IDX_W-1:0]       lk_idx;
  logic [IDX_W-1:0]       fl_idx;

  assign lk_idx   = lookup_addr[IDX_W-1:0];
  assign fl_idx   = fill_addr[IDX_W-1:0];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_addr);
  assign hit_data = data_q[lk_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fl_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fl_idx]  <= fill_addr;
      data_q[fl_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/logic_engine_responder.sv
// Target side of the CPU logic-engine port; forwards LASSERT queries to the solver.
// Optional result cache enabled by defining RESULT_CACHE_EN.
//
// state    | meaning
// ST_IDLE  | waiting for logic_req; cache lookup when enabled
// ST_ISSUE | solver_req_valid high until solver_req_ready
// ST_WAIT  | waiting for solver response, timeout timer running
// ST_ACK   | one-cycle logic_ack with certificate on logic_data
// ST_DRAIN | waiting for logic_req to drop
module logic_engine_responder
  import thiele_logic_pkg::*;
#(
  parameter logic [31:0] CERT_BASE      = 32'h0001_0000,
  parameter logic [31:0] CERT_STRIDE    = 32'h40,
  parameter int          CERT_IDX_W     = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
`ifdef RESULT_CACHE_EN
  parameter int          CACHE_DEPTH    = 4,
`endif
  parameter logic [31:0] ERR_CERT       = ERR_CERT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  logic_engine_responder_if.slave  bus,
  output logic                     busy,
  output logic [7:0]               err_count
);
  localparam int              TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [TIMER_W-1:0]      timer;
  logic [CERT_IDX_W-1:0]   cert_idx;
  logic                    ack_q;
  logic [31:0]             data_q;
  logic                    valid_q;
  logic [31:0]             addr_q;
  logic                    busy_q;
  logic [7:0]              err_q;
  logic                    rsp_err;
  logic                    rsp_refuted;
  logic [31:0]             cert_result;
  logic                    cache_hit;
  logic [31:0]             cache_data;

  assign rsp_refuted = (bus.solver_rsp_status == RSP_REFUTED);
  assign rsp_err     = !((bus.solver_rsp_status == RSP_PROVED) || rsp_refuted);
  assign cert_result = cert_addr(CERT_BASE, CERT_STRIDE, 32'(cert_idx)) | {31'b0, rsp_refuted};

`ifdef RESULT_CACHE_EN
  logic fill_en;
  assign fill_en = (state == ST_WAIT) && bus.solver_rsp_valid && !rsp_err;

  logic_result_cache #(.CACHE_DEPTH(CACHE_DEPTH)) u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (bus.logic_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (addr_q),
    .fill_data   (cert_result)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      cert_idx <= '0;
      ack_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.logic_req) begin
            addr_q <= bus.logic_addr;
            busy_q <= 1'b1;
            if (cache_hit) begin
              data_q <= cache_data;
              ack_q  <= 1'b1;
              state  <= ST_ACK;
            end else begin
              valid_q <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.solver_req_ready) begin
            valid_q <= 1'b0;
            timer   <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer <= timer + TIMER_W'(1);
          // A response on the final timer cycle takes priority over the timeout.
          if (bus.solver_rsp_valid) begin
            if (rsp_err) begin
              data_q <= ERR_CERT;
              err_q  <= (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end else begin
              data_q   <= cert_result;
              cert_idx <= cert_idx + CERT_IDX_W'(1);
            end
            ack_q <= 1'b1;
            state <= ST_ACK;
          end else if (timer == TIMER_LAST) begin
            data_q <= ERR_CERT;
            err_q  <= (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            ack_q  <= 1'b1;
            state  <= ST_ACK;
          end
        end
        ST_ACK: state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!bus.logic_req) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.logic_ack        = ack_q;
  assign bus.logic_data       = data_q;
  assign bus.solver_req_valid = valid_q;
  assign bus.solver_req_addr  = addr_q;
  assign busy                 = busy_q;
  assign err_count            = err_q;

endmodule

// File: tb/tb_logic_engine_responder.sv
// Scoreboard bench for logic_engine_responder (TIMEOUT_CYCLES=16, CERT_IDX_W=2).
module tb_logic_engine_responder;
  import thiele_logic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  logic_engine_responder_if bus();

  logic_engine_responder #(
    .TIMEOUT_CYCLES (16),
    .CERT_IDX_W     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  bit          prev_ack = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Monitor: every ack pops one expected certificate.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.logic_ack) begin
        check1("single_cycle_ack", prev_ack, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got data %h expected no ack", bus.logic_data);
        end else begin
          check32("ack_data", bus.logic_data, exp_q.pop_front());
        end
      end
      prev_ack = rst_n && bus.logic_ack;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 8) begin
      @(negedge clk);
      n++;
    end
    check1("back_to_idle", busy, 1'b0);
  endtask

  task automatic query(input logic [31:0] a, input int rdy_wait, input int rsp_dly,
                       input logic [1:0] st, input bit send_rsp, input bit drop_early,
                       input logic [31:0] exp, output int lat);
    int n;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.logic_req  = 1'b1;
    bus.logic_addr = a;
    n = 0;
    while (!bus.solver_req_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check1("issue_valid", bus.solver_req_valid, 1'b1);
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      check1("stall_valid", bus.solver_req_valid, 1'b1);
      check32("stall_addr", bus.solver_req_addr, a);
      check1("stall_no_ack", bus.logic_ack, 1'b0);
    end
    bus.solver_req_ready = 1'b1;
    @(negedge clk);
    bus.solver_req_ready = 1'b0;
    if (drop_early) bus.logic_req = 1'b0;
    lat = 0;
    if (send_rsp) begin
      repeat (rsp_dly) begin
        @(negedge clk);
        lat++;
      end
      bus.solver_rsp_valid  = 1'b1;
      bus.solver_rsp_status = st;
      @(negedge clk);
      lat++;
      bus.solver_rsp_valid = 1'b0;
    end
    while (!bus.logic_ack && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check1("ack_seen", bus.logic_ack, 1'b1);
    bus.logic_req = 1'b0;
    wait_idle();
  endtask

`ifdef RESULT_CACHE_EN
  task automatic hit_query(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.logic_req  = 1'b1;
    bus.logic_addr = a;
    @(negedge clk);
    check1("hit_ack_1cycle", bus.logic_ack, 1'b1);
    check1("hit_no_solver_req", bus.solver_req_valid, 1'b0);
    bus.logic_req = 1'b0;
    @(negedge clk);
    check1("hit_no_solver_req_drain", bus.solver_req_valid, 1'b0);
    wait_idle();
  endtask
`endif

  task automatic stale_rsp();
    bus.solver_rsp_valid  = 1'b1;
    bus.solver_rsp_status = RSP_PROVED;
    @(negedge clk);
    bus.solver_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check1("stale_rsp_ignored", busy, 1'b0);
  endtask

  initial begin
    int lat;
    int n;
    bus.logic_req         = 1'b0;
    bus.logic_addr        = '0;
    bus.solver_req_ready  = 1'b0;
    bus.solver_rsp_valid  = 1'b0;
    bus.solver_rsp_status = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_ack", bus.logic_ack, 1'b0);
    check1("rst_valid", bus.solver_req_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check32("rst_err_count", 32'(err_count), 32'h0);
    check32("rst_data", bus.logic_data, 32'h0);

    // Reset in the middle of WAIT, then a late response for the aborted query.
    bus.logic_req  = 1'b1;
    bus.logic_addr = 32'h99;
    n = 0;
    while (!bus.solver_req_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    bus.solver_req_ready = 1'b1;
    @(negedge clk);
    bus.solver_req_ready = 1'b0;
    bus.logic_req = 1'b0;
    repeat (2) @(negedge clk);
    check1("wait_busy_before_abort", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("abort_busy_async", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("abort_idle", busy, 1'b0);
    stale_rsp();

    // Stalled issue on addr 0x12, proved after 3 cycles -> slot 0.
    query(32'h12, 10, 3, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0000, lat);
    // Refuted -> slot 1 with bit0 set.
    query(32'h34, 0, 3, RSP_REFUTED, 1'b1, 1'b0, 32'h0001_0041, lat);

    // Repeat of addr 0x12.
`ifdef RESULT_CACHE_EN
    hit_query(32'h12, 32'h0001_0000);
`else
    query(32'h12, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0080, lat);
`endif

    // Timeout: ack 16 cycles after WAIT entry.
    query(32'h50, 0, 0, RSP_PROVED, 1'b0, 1'b0, 32'hFFFF_FFFF, lat);
    check32("timeout_latency", 32'(lat), 32'd16);
    check32("timeout_err_count", 32'(err_count), 32'd1);
    stale_rsp();

    query(32'h54, 0, 2, RSP_ERROR, 1'b1, 1'b0, 32'hFFFF_FFFF, lat);
    check32("status_err_count", 32'(err_count), 32'd2);

    // Response lands on the final timer cycle and must win.
`ifdef RESULT_CACHE_EN
    query(32'h58, 0, 15, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0080, lat);
`else
    query(32'h58, 0, 15, RSP_PROVED, 1'b1, 1'b0, 32'h0001_00C0, lat);
`endif
    check32("race_latency", 32'(lat), 32'd16);
    check32("race_err_count", 32'(err_count), 32'd2);

    // Fresh reset, then the 2-bit certificate counter wraps.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check32("rst2_err_count", 32'(err_count), 32'h0);
    query(32'h100, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0000, lat);
    query(32'h104, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0040, lat);
    query(32'h108, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0080, lat);
    query(32'h10C, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_00C0, lat);
    query(32'h110, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0000, lat);

    // Request dropped while waiting still completes and advances the slot.
    query(32'h200, 0, 2, RSP_PROVED, 1'b1, 1'b1, 32'h0001_0040, lat);
    query(32'h204, 0, 1, RSP_PROVED, 1'b1, 1'b0, 32'h0001_0080, lat);

    // err_count saturation.
    for (int i = 0; i < 255; i++) begin
      query(32'h1000 + 32'(i) * 4, 0, 0, RSP_ERROR, 1'b1, 1'b0, 32'hFFFF_FFFF, lat);
    end
    check32("err_count_255", 32'(err_count), 32'hFF);
    query(32'h2000, 0, 0, RSP_ERROR, 1'b1, 1'b0, 32'hFFFF_FFFF, lat);
    check32("err_count_saturated", 32'(err_count), 32'hFF);

    repeat (3) @(negedge clk);
    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
